tlu_controller_multi: RTL

//  Next-generation TLU trigger controller. Accepts TLU triggers, issues a start pulse to up to N_CH command

---
 rtl/tlu_pkg.sv | 27 ++
 rtl/tlu_word_fifo.sv | 50 +++++
 rtl/tlu_controller_multi.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/tlu_pkg.sv
// tlu_pkg: shared FSM encoding, TLU_MODE codes and FIFO word header
// bit positions for the TLU trigger controller.
package tlu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOW,
    S_CLOCK_OUT,
    S_STORE,
    S_WAIT_READY
  } state_t;

  localparam logic [1:0] MODE_NONE  = 2'd0;
  localparam logic [1:0] MODE_BUSY  = 2'd1;
  localparam logic [1:0] MODE_DATA  = 2'd2;
  localparam logic [1:0] MODE_COUNT = 2'd3;

  localparam int HDR_VALID       = 31;
  localparam int HDR_ACCEPT_ERR  = 30;
  localparam int HDR_TIMEOUT_ERR = 29;

  // Modes in which the TLU expects TLU_BUSY to be driven.
  function automatic logic is_handshake(input logic [1:0] mode);
    return (mode == MODE_BUSY) || (mode == MODE_DATA);
  endfunction

endpackage

// File: rtl/tlu_word_fifo.sv
// tlu_word_fifo: first-word-fall-through FIFO, power-of-2 depth.
// Ports: clk/rst_n, wr/din push, rd pop, dout head, full/empty/fill.
module tlu_word_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_rd;
  logic             do_wr;

  assign fill  = wptr - rptr;
  assign full  = (fill == DEPTH_F);
  assign empty = (fill == '0);
  assign do_rd = rd & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_wr = wr & (~full | do_rd);
  assign dout  = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tlu_controller_multi.sv
// tlu_controller_multi: accepts TLU triggers, pulses command starts, runs
// busy/clock handshake, reads trigger number and queues one word each.
// Ports: TLU_* handshake lines, CMD_* start fan-out, FIFO_* pop side,
// LOST_COUNT dropped words (saturating).
module tlu_controller_multi #(
  parameter int DIVISOR    = 12,
  parameter int N_CH       = 4,
  parameter int TRIG_WIDTH = 15,
  parameter int FIFO_DEPTH = 16
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            TLU_TRIGGER,
  input  logic [1:0]      TLU_MODE,
  input  logic [7:0]      TLU_LOW_TIMEOUT,
  input  logic [4:0]      TLU_CLOCK_CYCLES,
  input  logic [3:0]      TLU_DATA_DELAY,
  input  logic            TLU_MSB_FIRST,
  input  logic [N_CH-1:0] CMD_EXT_START_ENABLE,
  input  logic [N_CH-1:0] CMD_READY,
  output logic [N_CH-1:0] CMD_EXT_START_FLAG,
  output logic            TLU_BUSY,
  output logic            TLU_CLOCK,
  output logic            TLU_ASSERT_VETO,
  input  logic            FIFO_READ,
  output logic            FIFO_EMPTY,
  output logic [31:0]     FIFO_DATA,
  output logic [7:0]      LOST_COUNT
);

  import tlu_pkg::*;

  localparam int PW  = $clog2(DIVISOR);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int FW  = AW + 1;
  localparam int PAD = 29 - TRIG_WIDTH;
  localparam logic [PW-1:0] HALF_P   = PW'(DIVISOR / 2);
  localparam logic [PW-1:0] LAST_P   = PW'(DIVISOR - 1);
  localparam logic [5:0]    TW6      = 6'(TRIG_WIDTH);
  localparam logic [FW-1:0] VETO_LVL = FW'(FIFO_DEPTH - 2);

  state_t state;
  state_t state_n;

  logic                  trig_prev;
  logic                  rise;
  logic                  en;
  logic                  rdy;
  logic                  hs;
  logic [N_CH-1:0]       start_q;
  logic [N_CH-1:0]       start_n;
  logic                  busy_q;
  logic                  clk_q;
  logic                  veto_q;
  logic                  accept_err;
  logic                  timeout_err;
  logic                  set_acc;
  logic                  set_to;
  logic [7:0]            low_cnt;
  logic [7:0]            low_n;
  logic [7:0]            lost_q;
  logic [PW-1:0]         phase;
  logic [PW-1:0]         phase_n;
  logic [PW-1:0]         sample_phase;
  logic [5:0]            per_cnt;
  logic [5:0]            per_n;
  logic [5:0]            n_per;
  logic [TRIG_WIDTH-1:0] shift_q;
  logic [TRIG_WIDTH-1:0] counter;
  logic [TRIG_WIDTH-1:0] trig_sel;
  logic [TRIG_WIDTH:0]   shl;
  logic                  smp;
  logic                  push;
  logic                  fifo_full;
  logic [FW-1:0]         fill;
  logic [31:0]           word;

  assign en   = |CMD_EXT_START_ENABLE;
  assign rdy  = &(CMD_READY | ~CMD_EXT_START_ENABLE);
  assign rise = TLU_TRIGGER & ~trig_prev;
  assign hs   = is_handshake(TLU_MODE);

  assign n_per = (TLU_CLOCK_CYCLES == 5'd0) ? 6'd32
                                            : {1'b0, TLU_CLOCK_CYCLES};
  assign sample_phase =
    PW'((DIVISOR / 2 - 1 + int'(TLU_DATA_DELAY)) % DIVISOR);

  assign shl = {shift_q, TLU_TRIGGER};

  always_comb begin
    trig_sel = '0;
    if (TLU_MODE == MODE_DATA)  trig_sel = shift_q;
    if (TLU_MODE == MODE_COUNT) trig_sel = counter;
  end

  assign word = {1'b1, accept_err, timeout_err, {PAD{1'b0}}, trig_sel};

  always_comb begin
    state_n = state;
    phase_n = phase;
    per_n   = per_cnt;
    low_n   = low_cnt;
    start_n = '0;
    set_acc = 1'b0;
    set_to  = 1'b0;
    smp     = 1'b0;
    push    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rise) begin
          if (en && rdy) begin
            state_n = S_WAIT_LOW;
            start_n = CMD_EXT_START_ENABLE;
            low_n   = '0;
          end else begin
            set_acc = 1'b1;
          end
        end
      end
      S_WAIT_LOW: begin
        if (!hs) begin
          state_n = S_STORE;
        end else if (!TLU_TRIGGER ||
                     (TLU_LOW_TIMEOUT != 8'd0 &&
                      low_cnt >= TLU_LOW_TIMEOUT)) begin
          set_to  = TLU_TRIGGER;
          state_n = (TLU_MODE == MODE_DATA) ? S_CLOCK_OUT : S_STORE;
          phase_n = '0;
          per_n   = '0;
        end else if (low_cnt != 8'hFF) begin
          low_n = low_cnt + 8'd1;
        end
      end
      S_CLOCK_OUT: begin
        smp = (phase == sample_phase);
        if (phase == LAST_P) begin
          phase_n = '0;
          if (per_cnt == n_per - 6'd1) state_n = S_STORE;
          else                         per_n   = per_cnt + 6'd1;
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      S_STORE: begin
        push    = 1'b1;
        state_n = S_WAIT_READY;
      end
      S_WAIT_READY: begin
        if (rdy) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= S_IDLE;
      trig_prev   <= 1'b0;
      start_q     <= '0;
      busy_q      <= 1'b0;
      clk_q       <= 1'b0;
      veto_q      <= 1'b1;
      accept_err  <= 1'b0;
      timeout_err <= 1'b0;
      low_cnt     <= '0;
      phase       <= '0;
      per_cnt     <= '0;
      shift_q     <= '0;
      counter     <= '0;
      lost_q      <= '0;
    end else begin
      state     <= state_n;
      trig_prev <= TLU_TRIGGER;
      start_q   <= start_n;
      busy_q    <= hs && (state_n != S_IDLE);
      clk_q     <= (state_n == S_CLOCK_OUT) && (phase_n < HALF_P);
      veto_q    <= !en || (fill >= VETO_LVL);
      low_cnt   <= low_n;
      phase     <= phase_n;
      per_cnt   <= per_n;
      if (push) begin
        accept_err  <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        if (set_acc) accept_err  <= 1'b1;
        if (set_to)  timeout_err <= 1'b1;
      end
      if (state == S_WAIT_LOW && state_n == S_CLOCK_OUT) begin
        shift_q <= '0;
      end else if (smp) begin
        if (TLU_MSB_FIRST)
          shift_q <= shl[TRIG_WIDTH-1:0];
        else if (per_cnt < TW6)
          shift_q <= shift_q |
                     (TRIG_WIDTH'(TLU_TRIGGER) << per_cnt);
      end
      if (push && TLU_MODE == MODE_COUNT) counter <= counter + 1'b1;
      if (push && fifo_full && !FIFO_READ && lost_q != 8'hFF)
        lost_q <= lost_q + 8'd1;
    end
  end

  tlu_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .wr    (push),
    .din   (word),
    .rd    (FIFO_READ),
    .dout  (FIFO_DATA),
    .full  (fifo_full),
    .empty (FIFO_EMPTY),
    .fill  (fill)
  );

  assign CMD_EXT_START_FLAG = start_q;
  assign TLU_BUSY           = busy_q;
  assign TLU_CLOCK          = clk_q;
  assign TLU_ASSERT_VETO    = veto_q;
  assign LOST_COUNT         = lost_q;

endmodule
